// File: rtl/verisc_controller.sv
// rtl/verisc_controller.sv - VeriRISC instruction-cycle sequencer and strobe decoder
//
// Purpose:
//   Steps an 8-phase instruction cycle and decodes the phase, the latched opcode
//   and the accumulator zero flag into datapath strobes. Owns the halted state
//   and a wrapping counter of retired instructions.
//
// Ports:
//   clk     in   1         system clock, all state on posedge
//   rst     in   1         synchronous, active-high reset
//   opcode  in   3         IR opcode: HLT=0 SKZ=1 ADD=2 AND=3 XOR=4 LDA=5 STO=6 JMP=7
//   zero    in   1         accumulator == 0 (used in ALU_OP only)
//   stall   in   1         freeze sequencing while memory is not ready
//   resume  in   1         leave the halted state
//   sel     out  1         address mux: 1 = PC, 0 = IR operand
//   rd      out  1         memory read
//   wr      out  1         memory write
//   ld_ir   out  1         load IR
//   ld_ac   out  1         load accumulator
//   inc_pc  out  1         PC increment
//   ld_pc   out  1         PC load
//   data_e  out  1         drive accumulator onto data bus
//   halt    out  1         halt indication
//   halted  out  1         registered halted state
//   phase   out  3         current phase (debug)
//   icount  out  IC_WIDTH  retired instructions (wraps)

module verisc_controller #(
  parameter int IC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          opcode,
  input  logic                zero,
  input  logic                stall,
  input  logic                resume,
  output logic                sel,
  output logic                rd,
  output logic                wr,
  output logic                ld_ir,
  output logic                ld_ac,
  output logic                inc_pc,
  output logic                ld_pc,
  output logic                data_e,
  output logic                halt,
  output logic                halted,
  output logic [2:0]          phase,
  output logic [IC_WIDTH-1:0] icount
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t                phase_q, phase_d;
  logic                  halted_q, halted_d;
  logic [IC_WIDTH-1:0]   icount_q, icount_d;
  logic                  aluop;

  assign aluop  = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  assign phase  = phase_q;
  assign halted = halted_q;
  assign icount = icount_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
      icount_q <= '0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
      icount_q <= icount_d;
    end
  end

  // Next state. stall freezes everything, including a pending resume.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    icount_d = icount_q;
    if (!stall) begin
      if (halted_q) begin
        // Leaving halt retires the HLT instruction itself.
        if (resume) begin
          halted_d = 1'b0;
          phase_d  = INST_ADDR;
          icount_d = icount_q + 1'b1;
        end
      end else if (phase_q == OP_ADDR && opcode == OP_HLT) begin
        // Park in OP_ADDR; the wrap to INST_ADDR happens on resume.
        halted_d = 1'b1;
      end else begin
        phase_d = phase_t'(phase_q + 3'd1);
        if (phase_q == STORE) begin
          icount_d = icount_q + 1'b1;
        end
      end
    end
  end

  // Strobe decode.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;

    case (phase_q)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == OP_HLT);
      end
      OP_FETCH: begin
        rd = aluop;
      end
      ALU_OP: begin
        rd     = aluop;
        inc_pc = (opcode == OP_SKZ) && zero;
        ld_pc  = (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
      end
      STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = (opcode == OP_JMP);
        wr     = (opcode == OP_STO);
        data_e = (opcode == OP_STO);
      end
      default: begin
      end
    endcase

    // Edge-acting strobes only fire on an advancing edge; a reset edge aborts
    // the instruction so nothing it would load or write may fire either.
    if (stall || rst) begin
      ld_ir  = 1'b0;
      ld_ac  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      wr     = 1'b0;
    end

    if (halted_q) begin
      sel    = 1'b0;
      rd     = 1'b0;
      wr     = 1'b0;
      ld_ir  = 1'b0;
      ld_ac  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      halt   = 1'b1;
    end
  end

endmodule

// File: tb/tb_verisc_controller.sv
// tb/tb_verisc_controller.sv - directed self-checking bench for verisc_controller

module tb_verisc_controller;

  logic        clk;
  logic        rst;
  logic [2:0]  opcode;
  logic        zero;
  logic        stall;
  logic        resume;

  logic        sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt, halted;
  logic [2:0]  phase;
  logic [15:0] icount;

  logic        s_sel, s_rd, s_wr, s_ld_ir, s_ld_ac, s_inc_pc, s_ld_pc, s_data_e, s_halt, s_halted;
  logic [2:0]  s_phase;
  logic [1:0]  s_icount;

  logic [8:0]  stb;
  assign stb = {sel, rd, wr, ld_ir, ld_ac, inc_pc, ld_pc, data_e, halt};

  int n_checks;
  int n_fail;
  int exp_ic;

  verisc_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .stall(stall), .resume(resume),
    .sel(sel), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac), .inc_pc(inc_pc),
    .ld_pc(ld_pc), .data_e(data_e), .halt(halt), .halted(halted), .phase(phase),
    .icount(icount)
  );

  verisc_controller #(.IC_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .stall(stall), .resume(resume),
    .sel(s_sel), .rd(s_rd), .wr(s_wr), .ld_ir(s_ld_ir), .ld_ac(s_ld_ac), .inc_pc(s_inc_pc),
    .ld_pc(s_ld_pc), .data_e(s_data_e), .halt(s_halt), .halted(s_halted), .phase(s_phase),
    .icount(s_icount)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    #3;
    n_checks++;
    if (phase !== 3'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: phase=%0d halted=%b, expected phase=0 halted=0", phase, halted);
    end
    n_checks++;
    if (stb !== 9'b100000000) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected %b", stb, 9'b100000000);
    end
    n_checks++;
    if (icount !== 16'd0 || s_icount !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_icount: got %0d/%0d expected 0/0", icount, s_icount);
    end
    exp_ic = 0;
  endtask

  task automatic test_add();
    logic [8:0] exp [8];
    exp = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
            9'b000001000, 9'b010000000, 9'b010000000, 9'b010010000};
    opcode = 3'd2;
    zero   = 1'b0;
    for (int p = 0; p < 8; p++) begin
      #3;
      n_checks++;
      if (stb !== exp[p] || phase !== p[2:0]) begin
        n_fail++;
        $display("FAIL add_p%0d: strobes=%b phase=%0d expected strobes=%b phase=%0d",
                 p, stb, phase, exp[p], p);
      end
      step();
    end
    exp_ic++;
    #3;
    n_checks++;
    if (phase !== 3'd0 || icount !== exp_ic[15:0]) begin
      n_fail++;
      $display("FAIL add_retire: phase=%0d icount=%0d expected phase=0 icount=%0d",
               phase, icount, exp_ic);
    end
  endtask

  task automatic test_skz_jmp();
    logic [8:0] tbl [3][8];
    logic [2:0] ops [3];
    logic       zs  [3];
    tbl[0] = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
               9'b000001000, 9'b000000000, 9'b000001000, 9'b000000000};
    tbl[1] = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
               9'b000001000, 9'b000000000, 9'b000000000, 9'b000000000};
    tbl[2] = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
               9'b000001000, 9'b000000000, 9'b000000100, 9'b000000100};
    ops = '{3'd1, 3'd1, 3'd7};
    zs  = '{1'b1, 1'b0, 1'b0};
    for (int r = 0; r < 3; r++) begin
      opcode = ops[r];
      zero   = zs[r];
      for (int p = 0; p < 8; p++) begin
        #3;
        n_checks++;
        if (stb !== tbl[r][p] || phase !== p[2:0]) begin
          n_fail++;
          $display("FAIL skzjmp_r%0d_p%0d: strobes=%b phase=%0d expected strobes=%b phase=%0d",
                   r, p, stb, phase, tbl[r][p], p);
        end
        step();
      end
      exp_ic++;
      #3;
      n_checks++;
      if (icount !== exp_ic[15:0]) begin
        n_fail++;
        $display("FAIL skzjmp_retire_r%0d: icount=%0d expected %0d", r, icount, exp_ic);
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_sto_stall();
    logic [8:0] exp [7];
    int wr_cnt;
    exp = '{9'b100000000, 9'b110000000, 9'b110100000, 9'b110100000,
            9'b000001000, 9'b000000000, 9'b000000010};
    wr_cnt = 0;
    opcode = 3'd6;
    for (int p = 0; p < 7; p++) begin
      #3;
      n_checks++;
      if (stb !== exp[p]) begin
        n_fail++;
        $display("FAIL sto_p%0d: strobes=%b expected %b", p, stb, exp[p]);
      end
      if (wr === 1'b1) wr_cnt++;
      step();
    end
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #3;
      n_checks++;
      if (stb !== 9'b000000010 || phase !== 3'd7) begin
        n_fail++;
        $display("FAIL sto_stall_c%0d: strobes=%b phase=%0d expected strobes=000000010 phase=7",
                 c, stb, phase);
      end
      if (wr === 1'b1) wr_cnt++;
      step();
    end
    stall = 1'b0;
    #3;
    n_checks++;
    if (stb !== 9'b001000010) begin
      n_fail++;
      $display("FAIL sto_release: strobes=%b expected 001000010", stb);
    end
    if (wr === 1'b1) wr_cnt++;
    step();
    exp_ic++;
    #3;
    n_checks++;
    if (phase !== 3'd0 || icount !== exp_ic[15:0]) begin
      n_fail++;
      $display("FAIL sto_retire: phase=%0d icount=%0d expected phase=0 icount=%0d",
               phase, icount, exp_ic);
    end
    n_checks++;
    if (wr_cnt !== 1) begin
      n_fail++;
      $display("FAIL sto_write_count: got %0d expected 1", wr_cnt);
    end
  endtask

  task automatic test_hlt();
    int inc_cnt;
    inc_cnt = 0;
    opcode = 3'd0;
    for (int p = 0; p < 4; p++) begin
      if (inc_pc === 1'b1) inc_cnt++;
      step();
    end
    #3;
    n_checks++;
    if (stb !== 9'b000001001 || phase !== 3'd4) begin
      n_fail++;
      $display("FAIL hlt_op_addr: strobes=%b phase=%0d expected strobes=000001001 phase=4",
               stb, phase);
    end
    if (inc_pc === 1'b1) inc_cnt++;
    step();
    for (int c = 0; c < 10; c++) begin
      #3;
      n_checks++;
      if (halted !== 1'b1 || phase !== 3'd4 || stb !== 9'b000000001 || icount !== exp_ic[15:0]) begin
        n_fail++;
        $display("FAIL hlt_hold_c%0d: halted=%b phase=%0d strobes=%b icount=%0d expected 1/4/000000001/%0d",
                 c, halted, phase, stb, icount, exp_ic);
      end
      if (inc_pc === 1'b1) inc_cnt++;
      step();
    end
    n_checks++;
    if (inc_cnt !== 1) begin
      n_fail++;
      $display("FAIL hlt_inc_pc_count: got %0d expected 1", inc_cnt);
    end
    stall  = 1'b1;
    resume = 1'b1;
    step();
    #3;
    n_checks++;
    if (halted !== 1'b1 || phase !== 3'd4) begin
      n_fail++;
      $display("FAIL hlt_stall_over_resume: halted=%b phase=%0d expected halted=1 phase=4",
               halted, phase);
    end
    stall = 1'b0;
    step();
    resume = 1'b0;
    exp_ic++;
    #3;
    n_checks++;
    if (halted !== 1'b0 || phase !== 3'd0 || icount !== exp_ic[15:0] || stb !== 9'b100000000) begin
      n_fail++;
      $display("FAIL hlt_resume: halted=%b phase=%0d icount=%0d strobes=%b expected 0/0/%0d/100000000",
               halted, phase, icount, stb, exp_ic);
    end
    resume = 1'b1;
    step();
    resume = 1'b0;
    #3;
    n_checks++;
    if (halted !== 1'b0 || phase !== 3'd1 || icount !== exp_ic[15:0]) begin
      n_fail++;
      $display("FAIL resume_while_running: halted=%b phase=%0d icount=%0d expected 0/1/%0d",
               halted, phase, icount, exp_ic);
    end
    opcode = 3'd2;
    repeat (7) step();
    exp_ic++;
    #3;
    n_checks++;
    if (phase !== 3'd0 || icount !== exp_ic[15:0]) begin
      n_fail++;
      $display("FAIL post_resume_retire: phase=%0d icount=%0d expected phase=0 icount=%0d",
               phase, icount, exp_ic);
    end
  endtask

  task automatic test_rst_mid();
    int ldpc_cnt;
    ldpc_cnt = 0;
    opcode = 3'd7;
    for (int p = 0; p < 6; p++) begin
      if (ld_pc === 1'b1) ldpc_cnt++;
      step();
    end
    rst = 1'b1;
    #3;
    if (ld_pc === 1'b1) ldpc_cnt++;
    n_checks++;
    if (phase !== 3'd6 || stb !== 9'b000000000) begin
      n_fail++;
      $display("FAIL rst_mid_strobes: phase=%0d strobes=%b expected phase=6 strobes=000000000",
               phase, stb);
    end
    step();
    rst = 1'b0;
    exp_ic = 0;
    #3;
    n_checks++;
    if (phase !== 3'd0 || icount !== 16'd0 || halted !== 1'b0 || ldpc_cnt !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_after: phase=%0d icount=%0d halted=%b ld_pc_pulses=%0d expected 0/0/0/0",
               phase, icount, halted, ldpc_cnt);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_s [6];
    exp_s = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    opcode = 3'd2;
    for (int i = 0; i < 6; i++) begin
      #3;
      n_checks++;
      if (s_icount !== exp_s[i] || icount !== i[15:0]) begin
        n_fail++;
        $display("FAIL wrap_i%0d: icount2=%0d icount16=%0d expected %0d/%0d",
                 i, s_icount, icount, exp_s[i], i);
      end
      if (i < 5) repeat (8) step();
    end
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b1;
    opcode   = 3'd0;
    zero     = 1'b0;
    stall    = 1'b0;
    resume   = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    exp_ic   = 0;

    test_reset();
    test_add();
    test_skz_jmp();
    test_sto_stall();
    test_hlt();
    test_rst_mid();
    test_wrap();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
